// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pic_pkg
//  Purpose  : Shared definitions for the 8259 command-word register stage:
//             sequencer state encoding, command-word bit positions and the
//             OCW2 command encodings seen on ocw2_cmd.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package pic_pkg;

    // Initialization sequencer states
    typedef enum logic [2:0] {
        UNINIT    = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } state_t;

    // ICW1 bit positions
    localparam int c_LTIM_BIT = 3;
    localparam int c_SNGL_BIT = 1;
    localparam int c_IC4_BIT  = 0;

    // ICW4 bit positions (BUF and M/S occupy bits 3:2)
    localparam int c_SFNM_BIT = 4;
    localparam int c_BUF_MSB  = 3;
    localparam int c_BUF_LSB  = 2;
    localparam int c_AEOI_BIT = 1;

    // OCW3 bit positions
    localparam int c_ESMM_BIT = 6;
    localparam int c_SMM_BIT  = 5;
    localparam int c_P_BIT    = 2;
    localparam int c_RR_BIT   = 1;
    localparam int c_RIS_BIT  = 0;

    // OCW2 command encodings, R/SL/EOI in bits 7:5
    localparam logic [2:0] ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] NS_EOI       = 3'b001;
    localparam logic [2:0] NO_OP        = 3'b010;
    localparam logic [2:0] SP_EOI       = 3'b011;
    localparam logic [2:0] ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] ROT_NS       = 3'b101;
    localparam logic [2:0] SET_PRIORITY = 3'b110;
    localparam logic [2:0] ROT_SP       = 3'b111;

endpackage
`default_nettype wire

// File: rtl/icw_ocw_sequencer_strobe_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module   : strobe_edge_detect
//  Purpose  : Turns a level write strobe into a single-cycle pulse on its
//             rising edge, so a strobe held for several clocks acts once.
//  Ports    : clock  - system clock
//             reset  - synchronous active-high reset
//             strobe - level write strobe
//             pulse  - high in the first cycle strobe is high
//  Revision : 1.0  initial release
// ============================================================================
module strobe_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic strobe,
    output logic pulse
);

    logic r_strobe_q;

    // Clearing on reset means a strobe already high at reset release is seen
    // as a fresh edge in the following cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_strobe_q <= 1'b0;
        end else begin
            r_strobe_q <= strobe;
        end
    end

    assign pulse = strobe & ~r_strobe_q;

endmodule
`default_nettype wire

// File: rtl/icw_ocw_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : icw_ocw_sequencer
//  Purpose  : 8259 command-word register stage. Runs the ICW1->ICW2->[ICW3]->
//             [ICW4] initialization sequence, latches mode/configuration
//             fields, then holds the OCW1 mask and OCW3 read select and
//             issues OCW2 command pulses.
//  Ports    : clock, reset (sync, active high)
//             internal_data_bus, five write strobes from bus control
//             ICW fields : level_or_edge_triggered, single_mode,
//                          interrupt_vector, cascade_config, auto_eoi,
//                          buffered_mode, special_fully_nested
//             OCW state  : interrupt_mask, read_isr_select, poll_command,
//                          ocw2_valid, ocw2_cmd, ocw2_level,
//                          special_mask_mode
//             init_done  : high in READY
//  Options  : SPECIAL_MASK_MODE_EN - when defined, OCW3 ESMM/SMM drive
//             special_mask_mode; otherwise that output is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module icw_ocw_sequencer
    import pic_pkg::*;
#(
    parameter int VECTOR_W = 5,
    parameter int IRQ_N    = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          internal_data_bus,
    input  logic                write_initial_command_word_1_reset,
    input  logic                write_initial_command_word_2_4,
    input  logic                write_operation_control_word_1,
    input  logic                write_operation_control_word_2,
    input  logic                write_operation_control_word_3,
    output logic                level_or_edge_triggered,
    output logic                single_mode,
    output logic [VECTOR_W-1:0] interrupt_vector,
    output logic [7:0]          cascade_config,
    output logic                auto_eoi,
    output logic [1:0]          buffered_mode,
    output logic                special_fully_nested,
    output logic [IRQ_N-1:0]    interrupt_mask,
    output logic                read_isr_select,
    output logic                poll_command,
    output logic                ocw2_valid,
    output logic [2:0]          ocw2_cmd,
    output logic [2:0]          ocw2_level,
    output logic                special_mask_mode,
    output logic                init_done
);

    localparam int c_NUM_STROBES = 5;
    localparam int c_IDX_ICW1    = 0;
    localparam int c_IDX_ICW24   = 1;
    localparam int c_IDX_OCW1    = 2;
    localparam int c_IDX_OCW2    = 3;
    localparam int c_IDX_OCW3    = 4;

    logic [c_NUM_STROBES-1:0] w_strobe;
    logic [c_NUM_STROBES-1:0] w_pulse;
    state_t                   r_state;
    logic                     r_ic4;

    assign w_strobe[c_IDX_ICW1]  = write_initial_command_word_1_reset;
    assign w_strobe[c_IDX_ICW24] = write_initial_command_word_2_4;
    assign w_strobe[c_IDX_OCW1]  = write_operation_control_word_1;
    assign w_strobe[c_IDX_OCW2]  = write_operation_control_word_2;
    assign w_strobe[c_IDX_OCW3]  = write_operation_control_word_3;

    genvar gi;
    generate
        for (gi = 0; gi < c_NUM_STROBES; gi++) begin : g_strobe
            strobe_edge_detect u_edge (
                .clock  (clock),
                .reset  (reset),
                .strobe (w_strobe[gi]),
                .pulse  (w_pulse[gi])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state                 <= UNINIT;
            r_ic4                   <= 1'b0;
            level_or_edge_triggered <= 1'b0;
            single_mode             <= 1'b0;
            interrupt_vector        <= '0;
            cascade_config          <= 8'h00;
            auto_eoi                <= 1'b0;
            buffered_mode           <= 2'b00;
            special_fully_nested    <= 1'b0;
            interrupt_mask          <= '0;
            read_isr_select         <= 1'b0;
            poll_command            <= 1'b0;
            ocw2_valid              <= 1'b0;
            ocw2_cmd                <= 3'b000;
            ocw2_level              <= 3'b000;
            init_done               <= 1'b0;
        end else begin
            // Single-cycle outputs default low every cycle.
            poll_command <= 1'b0;
            ocw2_valid   <= 1'b0;

            if (w_pulse[c_IDX_ICW1]) begin
                // ICW1 restarts initialization from any state and swallows
                // any other strobe edge in the same cycle.
                level_or_edge_triggered <= internal_data_bus[c_LTIM_BIT];
                single_mode             <= internal_data_bus[c_SNGL_BIT];
                r_ic4                   <= internal_data_bus[c_IC4_BIT];
                interrupt_mask          <= '0;
                read_isr_select         <= 1'b0;
                auto_eoi                <= 1'b0;
                buffered_mode           <= 2'b00;
                special_fully_nested    <= 1'b0;
                cascade_config          <= 8'h00;
                init_done               <= 1'b0;
                r_state                 <= WAIT_ICW2;
            end else begin
                // The state decides which A0=1 strobe is honoured: ICW2_4
                // during initialization, OCW1 only once READY.
                case (r_state)
                    WAIT_ICW2: begin
                        if (w_pulse[c_IDX_ICW24]) begin
                            interrupt_vector <= internal_data_bus[7 -: VECTOR_W];
                            if (!single_mode) begin
                                r_state <= WAIT_ICW3;
                            end else if (r_ic4) begin
                                r_state <= WAIT_ICW4;
                            end else begin
                                r_state   <= READY;
                                init_done <= 1'b1;
                            end
                        end
                    end
                    WAIT_ICW3: begin
                        if (w_pulse[c_IDX_ICW24]) begin
                            cascade_config <= internal_data_bus;
                            if (r_ic4) begin
                                r_state <= WAIT_ICW4;
                            end else begin
                                r_state   <= READY;
                                init_done <= 1'b1;
                            end
                        end
                    end
                    WAIT_ICW4: begin
                        if (w_pulse[c_IDX_ICW24]) begin
                            // Bit 0 (uPM) is not stored: only 8086 mode exists.
                            special_fully_nested <= internal_data_bus[c_SFNM_BIT];
                            buffered_mode        <= internal_data_bus[c_BUF_MSB:c_BUF_LSB];
                            auto_eoi             <= internal_data_bus[c_AEOI_BIT];
                            r_state              <= READY;
                            init_done            <= 1'b1;
                        end
                    end
                    READY: begin
                        if (w_pulse[c_IDX_OCW1]) begin
                            interrupt_mask <= internal_data_bus[IRQ_N-1:0];
                        end
                        if (w_pulse[c_IDX_OCW2]) begin
                            ocw2_valid <= 1'b1;
                            ocw2_cmd   <= internal_data_bus[7:5];
                            ocw2_level <= internal_data_bus[2:0];
                        end
                        if (w_pulse[c_IDX_OCW3]) begin
                            if (internal_data_bus[c_RR_BIT]) begin
                                read_isr_select <= internal_data_bus[c_RIS_BIT];
                            end
                            if (internal_data_bus[c_P_BIT]) begin
                                poll_command <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        // UNINIT: only ICW1 leaves this state.
                    end
                endcase
            end
        end
    end

`ifdef SPECIAL_MASK_MODE_EN
    logic r_special_mask_mode;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_special_mask_mode <= 1'b0;
        end else if (w_pulse[c_IDX_ICW1]) begin
            r_special_mask_mode <= 1'b0;
        end else if ((r_state == READY) && w_pulse[c_IDX_OCW3] &&
                     internal_data_bus[c_ESMM_BIT]) begin
            r_special_mask_mode <= internal_data_bus[c_SMM_BIT];
        end
    end

    assign special_mask_mode = r_special_mask_mode;
`else
    assign special_mask_mode = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icw_ocw_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icw_ocw_sequencer
//  Purpose  : Directed self-checking bench for icw_ocw_sequencer. Walks the
//             single and cascade initialization paths, OCW1/2/3 handling,
//             re-initialization and reset in the middle of a sequence.
//  Revision : 1.0  initial release
// ============================================================================
module tb_icw_ocw_sequencer;

    localparam int SEL_ICW1  = 0;
    localparam int SEL_ICW24 = 1;
    localparam int SEL_OCW1  = 2;
    localparam int SEL_OCW2  = 3;
    localparam int SEL_OCW3  = 4;
    localparam int SEL_BOTH  = 5;   // ICW2_4 and OCW1 together (one A0=1 write)

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       s_icw1, s_icw24, s_ocw1, s_ocw2, s_ocw3;

    logic       level_or_edge_triggered, single_mode, auto_eoi;
    logic       special_fully_nested, read_isr_select, poll_command;
    logic       ocw2_valid, special_mask_mode, init_done;
    logic [4:0] interrupt_vector;
    logic [7:0] cascade_config, interrupt_mask;
    logic [1:0] buffered_mode;
    logic [2:0] ocw2_cmd, ocw2_level;

    int tests_run = 0;
    int tests_failed = 0;

    // Pulse monitor, sampled on the falling edge
    int         valid_cnt = 0;
    int         poll_cnt  = 0;
    logic [2:0] seen_cmd  = 3'b000;
    logic [2:0] seen_lvl  = 3'b000;
    int         base_v, base_p;

    always #5 clk = ~clk;

    icw_ocw_sequencer #(.VECTOR_W(5), .IRQ_N(8)) u_dut (
        .clock                              (clk),
        .reset                              (rst),
        .internal_data_bus                  (data),
        .write_initial_command_word_1_reset (s_icw1),
        .write_initial_command_word_2_4     (s_icw24),
        .write_operation_control_word_1     (s_ocw1),
        .write_operation_control_word_2     (s_ocw2),
        .write_operation_control_word_3     (s_ocw3),
        .level_or_edge_triggered            (level_or_edge_triggered),
        .single_mode                        (single_mode),
        .interrupt_vector                   (interrupt_vector),
        .cascade_config                     (cascade_config),
        .auto_eoi                           (auto_eoi),
        .buffered_mode                      (buffered_mode),
        .special_fully_nested               (special_fully_nested),
        .interrupt_mask                     (interrupt_mask),
        .read_isr_select                    (read_isr_select),
        .poll_command                       (poll_command),
        .ocw2_valid                         (ocw2_valid),
        .ocw2_cmd                           (ocw2_cmd),
        .ocw2_level                         (ocw2_level),
        .special_mask_mode                  (special_mask_mode),
        .init_done                          (init_done)
    );

    always @(negedge clk) begin
        if (ocw2_valid) begin
            valid_cnt = valid_cnt + 1;
            seen_cmd  = ocw2_cmd;
            seen_lvl  = ocw2_level;
        end
        if (poll_command) begin
            poll_cnt = poll_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_strobe(input int sel, input logic v);
        case (sel)
            SEL_ICW1:  s_icw1  = v;
            SEL_ICW24: s_icw24 = v;
            SEL_OCW1:  s_ocw1  = v;
            SEL_OCW2:  s_ocw2  = v;
            SEL_OCW3:  s_ocw3  = v;
            default: begin
                s_icw24 = v;
                s_ocw1  = v;
            end
        endcase
    endtask

    // Hold a strobe for 'cycles' clocks, then drop it and idle one clock.
    task automatic write_word(input int sel, input logic [7:0] d, input int cycles);
        data = d;
        set_strobe(sel, 1'b1);
        repeat (cycles) @(posedge clk);
        #1;
        set_strobe(sel, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; data = 8'h00;
        s_icw1 = 1'b0; s_icw24 = 1'b0; s_ocw1 = 1'b0; s_ocw2 = 1'b0; s_ocw3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_mask", {24'd0, interrupt_mask}, 32'h00);
        chk("rst_vector", {27'd0, interrupt_vector}, 32'd0);
        chk("rst_smm", {31'd0, special_mask_mode}, 32'd0);

        // Single mode with ICW4; OCW2 before init must not pulse
        write_word(SEL_ICW1, 8'h13, 1);
        base_v = valid_cnt;
        write_word(SEL_OCW2, 8'h63, 1);
        chk("ocw2_before_init", valid_cnt - base_v, 32'd0);
        write_word(SEL_ICW24, 8'h20, 1);
        chk("s_vector", {27'd0, interrupt_vector}, 32'h04);
        chk("s_done_after_icw2", {31'd0, init_done}, 32'd0);
        write_word(SEL_ICW24, 8'h03, 1);
        chk("s_single", {31'd0, single_mode}, 32'd1);
        chk("s_aeoi", {31'd0, auto_eoi}, 32'd1);
        chk("s_no_icw3", {24'd0, cascade_config}, 32'h00);
        chk("s_done", {31'd0, init_done}, 32'd1);

        // Cascade mode without ICW4; A0=1 write with both strobes goes to ICW2
        write_word(SEL_ICW1, 8'h10, 1);
        chk("c_aeoi_cleared", {31'd0, auto_eoi}, 32'd0);
        write_word(SEL_BOTH, 8'h40, 1);
        chk("c_vector", {27'd0, interrupt_vector}, 32'h08);
        chk("c_mask_not_loaded", {24'd0, interrupt_mask}, 32'h00);
        write_word(SEL_ICW24, 8'h04, 1);
        chk("c_cascade", {24'd0, cascade_config}, 32'h04);
        chk("c_done", {31'd0, init_done}, 32'd1);
        chk("c_single", {31'd0, single_mode}, 32'd0);
        write_word(SEL_ICW24, 8'hFF, 1);
        chk("c_icw24_ready_ignored", {24'd0, cascade_config}, 32'h04);

        // OCW1 mask
        write_word(SEL_OCW1, 8'hA5, 1);
        chk("ocw1_mask", {24'd0, interrupt_mask}, 32'hA5);

        // OCW2 with a 3-cycle strobe: one pulse only
        base_v = valid_cnt;
        write_word(SEL_OCW2, 8'h63, 3);
        chk("ocw2_pulses", valid_cnt - base_v, 32'd1);
        chk("ocw2_cmd", {29'd0, seen_cmd}, 32'b011);
        chk("ocw2_level", {29'd0, seen_lvl}, 32'd3);
        chk("ocw2_valid_low", {31'd0, ocw2_valid}, 32'd0);

        // OCW3 read select and poll
        base_p = poll_cnt;
        write_word(SEL_OCW3, 8'h0B, 1);
        chk("ocw3_ris", {31'd0, read_isr_select}, 32'd1);
        chk("ocw3_no_poll", poll_cnt - base_p, 32'd0);
        write_word(SEL_OCW3, 8'h0C, 2);
        chk("ocw3_poll_once", poll_cnt - base_p, 32'd1);
        chk("ocw3_ris_kept", {31'd0, read_isr_select}, 32'd1);

        // Special mask mode
        write_word(SEL_OCW3, 8'h68, 1);
`ifdef SPECIAL_MASK_MODE_EN
        chk("smm_set", {31'd0, special_mask_mode}, 32'd1);
`else
        chk("smm_tied", {31'd0, special_mask_mode}, 32'd0);
`endif

        // Re-initialization clears the mask and OCW3 state
        write_word(SEL_ICW1, 8'h13, 1);
        chk("reinit_mask", {24'd0, interrupt_mask}, 32'h00);
        chk("reinit_done", {31'd0, init_done}, 32'd0);
        chk("reinit_ris", {31'd0, read_isr_select}, 32'd0);
        chk("reinit_smm", {31'd0, special_mask_mode}, 32'd0);

        // Reset mid-sequence aborts to UNINIT
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        write_word(SEL_ICW24, 8'h20, 1);
        chk("midrst_vector", {27'd0, interrupt_vector}, 32'd0);
        write_word(SEL_ICW24, 8'h03, 1);
        chk("midrst_aeoi", {31'd0, auto_eoi}, 32'd0);
        chk("midrst_done", {31'd0, init_done}, 32'd0);
        chk("midrst_ltim", {31'd0, level_or_edge_triggered}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
